// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one single-port synchronous RAM (1-cycle read
// latency) between the LSU (port 0) and instruction fetch (port 1).
//   clock, reset            : system clock, synchronous active-high reset
//   lsu_* request/response  : valid/ready request, one-cycle response pulse
//   ifu_* request/response  : read-only fetch, flush discards a returning word
//   mem_*                   : shared RAM port, mem_rdata valid 1 cycle after read
// Arbitration is combinational; a starvation counter lets the IFU win a
// contention after MAX_WAIT consecutive blocked cycles.
module dmem_port_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [1:0]        lsu_mask,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_rdata,
  input  logic              ifu_valid,
  output logic              ifu_ready,
  input  logic [ADDR_W-1:0] ifu_addr,
  input  logic              ifu_flush,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_rdata,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_mask,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W     = 4;
  localparam logic [1:0]  MASK_WORD = 2'b10;

  logic [CNT_W-1:0] wait_cnt;
  logic             resp_pend;
  logic             resp_owner;  // 0 = LSU, 1 = IFU
  logic             resp_flush;
  logic             resp_store;
  logic             ifu_wins;
  logic             lsu_gnt;
  logic             ifu_gnt;

  // Grant selection: LSU has priority unless the IFU has starved long enough.
  always_comb begin
    ifu_wins = ifu_valid && (!lsu_valid || (wait_cnt == CNT_W'(MAX_WAIT)));
    ifu_gnt  = !reset && ifu_wins;
    lsu_gnt  = !reset && lsu_valid && !ifu_wins;
  end

  assign lsu_ready = lsu_gnt;
  assign ifu_ready = ifu_gnt;

  // Memory port mux; all fields forced to zero when idle.
  always_comb begin
    mem_en    = 1'b0;
    mem_addr  = '0;
    mem_wen   = 1'b0;
    mem_wdata = '0;
    mem_mask  = 2'b00;
    if (lsu_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = lsu_addr;
      mem_wen   = lsu_wen;
      mem_wdata = lsu_wdata;
      mem_mask  = lsu_mask;
    end else if (ifu_gnt) begin
      mem_en   = 1'b1;
      mem_addr = ifu_addr;
      mem_mask = MASK_WORD;
    end
  end

  // Response tracking and starvation counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_pend  <= 1'b0;
      resp_owner <= 1'b0;
      resp_flush <= 1'b0;
      resp_store <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      resp_pend  <= lsu_gnt || ifu_gnt;
      resp_owner <= ifu_gnt;
      resp_flush <= ifu_gnt && ifu_flush;
      resp_store <= lsu_gnt && lsu_wen;
      if (ifu_gnt) begin
        wait_cnt <= '0;
      end else if (ifu_valid && (wait_cnt != CNT_W'(MAX_WAIT))) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end
  end

  // Response pulses; a flush in either the grant or response cycle drops the
  // fetch word, and nothing is reported while reset is held.
  always_comb begin
    lsu_resp_valid = !reset && resp_pend && !resp_owner;
    ifu_resp_valid = !reset && resp_pend && resp_owner && !resp_flush && !ifu_flush;
    lsu_rdata      = (lsu_resp_valid && !resp_store) ? mem_rdata : '0;
    ifu_rdata      = ifu_resp_valid ? mem_rdata : '0;
  end

endmodule
